mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous word memory between the pipeline's instruction-fetch port and data (load/store) port.
- Grants at most one access per cycle and routes read data back to the owning requester one cycle later.
- Prevents fetch starvation with a bounded-wait counter.
- Sits between the pipeline datapath's IF/MEM stages and a unified instruction/data RAM.

---
 rtl/arb_pkg.sv | 17 +
 rtl/arb_starve_ctr.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package arb_pkg;

    localparam int WORD_W               = 32;
    localparam int BE_W                 = 4;
    localparam int AW_DEFAULT           = 12;
    localparam int STARVE_LIMIT_DEFAULT = 4;
    // Wide enough for the largest legal starvation limit (15).
    localparam int STARVE_CTR_W         = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive cycles in which a pending fetch lost to data.
module arb_starve_ctr
    import arb_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_limit_o
);

    localparam logic [STARVE_CTR_W-1:0] LIM = STARVE_CTR_W'(LIMIT);

    logic [STARVE_CTR_W-1:0] cnt_q;
    logic [STARVE_CTR_W-1:0] cnt_d;

    // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIM)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store accesses onto one single-port word RAM.
// Optional ARB_PERF_CNT_EN adds grant and conflict performance counters.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int AW           = AW_DEFAULT,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [WORD_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [AW-1:0]     d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    input  logic [BE_W-1:0]   d_be,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [WORD_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [BE_W-1:0]   mem_be,
    output logic [AW-3:0]     mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_if_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_conflicts
`endif
);

    owner_e            owner_q;
    owner_e            owner_d;
    logic [WORD_W-1:0] if_rdata_q;
    logic [WORD_W-1:0] d_rdata_q;

    logic if_req_eff;
    logic fetch_wins;
    logic at_limit;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

    // A redirecting fetch is treated as absent, so data may take the slot.
    assign if_req_eff = if_req & ~if_flush;
    assign fetch_wins = if_req_eff & (~d_req | at_limit);
    assign if_gnt     = reset & fetch_wins;
    assign d_gnt      = reset & d_req & ~fetch_wins;

    arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (if_gnt | ~if_req_eff),
        .inc_i      (if_req_eff & d_gnt),
        .at_limit_o (at_limit)
    );

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        owner_d   = OWN_NONE;
        if (if_gnt) begin
            mem_en   = 1'b1;
            mem_be   = '1;
            mem_addr = if_addr[AW-1:2];
            owner_d  = OWN_IF;
        end else if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_be    = d_we ? d_be : '1;
            mem_addr  = d_addr[AW-1:2];
            mem_wdata = d_wdata;
            owner_d   = d_we ? OWN_NONE : OWN_D;
        end
    end

    // Responses come straight from the RAM in the cycle after the read grant.
    assign if_rvalid = (owner_q == OWN_IF) & ~if_flush;
    assign d_rvalid  = (owner_q == OWN_D);
    assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
    assign d_rdata   = d_rvalid ? mem_rdata : d_rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q    <= OWN_NONE;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            owner_q <= owner_d;
            if (if_rvalid) begin
                if_rdata_q <= mem_rdata;
            end
            if (d_rvalid) begin
                d_rdata_q <= mem_rdata;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_if_grants <= '0;
            perf_d_grants  <= '0;
            perf_conflicts <= '0;
        end else begin
            if (if_gnt) begin
                perf_if_grants <= perf_if_grants + 32'd1;
            end
            if (d_gnt) begin
                perf_d_grants <= perf_d_grants + 32'd1;
            end
            if (if_req && d_req) begin
                perf_conflicts <= perf_conflicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios then randomized traffic.
module tb_mem_port_arbiter;

    localparam int AW    = 12;
    localparam int LIMIT = 4;
    localparam int WORDS = 1 << (AW - 2);

    logic          clk;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_flush;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic [3:0]    d_be;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-3:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    mem_port_arbiter #(
        .AW           (AW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Synchronous single-port RAM attached to the memory side.
    logic [31:0] ram [WORDS];
    logic        ram_ready = 1'b0;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < WORDS; i++) ram[i] <= init_word(i);
            ram_ready <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    // Reference model: expected memory contents, fetch starvation count, pending responses.
    typedef struct {
        int          cyc;
        logic [31:0] data;
    } resp_t;

    resp_t       if_q[$];
    resp_t       d_q[$];
    logic [31:0] shadow [WORDS];
    int          denied      = 0;
    bit          last_if_gnt = 1'b0;

    task automatic drive_cycle(input logic ir, input logic [AW-1:0] ia, input logic fl,
                               input logic dr, input logic dwe, input logic [AW-1:0] da,
                               input logic [31:0] dwd, input logic [3:0] dbe,
                               output logic gi, output logic gd);
        bit    fe;
        bit    exp_if;
        bit    exp_d;
        int    w;
        resp_t e;
        @(negedge clk);
        if_req = ir; if_addr = ia; if_flush = fl;
        d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd; d_be = dbe;
        #1;
        if (fl && last_if_gnt && if_q.size() > 0) void'(if_q.pop_back());
        fe     = ir && !fl;
        exp_if = fe && (!dr || denied == LIMIT);
        exp_d  = dr && !exp_if;
        check("if_gnt", {31'd0, if_gnt}, {31'd0, exp_if});
        check("d_gnt", {31'd0, d_gnt}, {31'd0, exp_d});
        check("mem_en", {31'd0, mem_en}, {31'd0, exp_if || exp_d});
        if (exp_if) begin
            w = int'(ia) >> 2;
            check("mem_addr_if", 32'(mem_addr), 32'(w));
            check("mem_we_if", {31'd0, mem_we}, 32'd0);
            check("mem_be_if", {28'd0, mem_be}, 32'hF);
            e.cyc = cyc; e.data = shadow[w];
            if_q.push_back(e);
        end else if (exp_d) begin
            w = int'(da) >> 2;
            check("mem_addr_d", 32'(mem_addr), 32'(w));
            check("mem_we_d", {31'd0, mem_we}, {31'd0, dwe});
            check("mem_be_d", {28'd0, mem_be}, dwe ? {28'd0, dbe} : 32'hF);
            if (dwe) begin
                check("mem_wdata", mem_wdata, dwd);
                for (int b = 0; b < 4; b++)
                    if (dbe[b]) shadow[w][8*b +: 8] = dwd[8*b +: 8];
            end else begin
                e.cyc = cyc; e.data = shadow[w];
                d_q.push_back(e);
            end
        end
        if (exp_if || !fe) denied = 0;
        else if (denied < LIMIT) denied++;
        last_if_gnt = exp_if;
        gi = if_gnt;
        gd = d_gnt;
    endtask

    task automatic idle_cycle();
        logic gi, gd;
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0, gi, gd);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        if_q.delete();
        d_q.delete();
        denied      = 0;
        last_if_gnt = 1'b0;
        #1;
        check("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
        check("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_be", {28'd0, mem_be}, 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        check("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        @(negedge clk);
        if_req = 1'b0; if_flush = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;
        reset = 1'b1;
    endtask

    // Monitor: pops the expected response whenever a valid appears, checks held data otherwise.
    logic [31:0] held_if = '0;
    logic [31:0] held_d  = '0;

    always @(negedge clk) begin
        resp_t e;
        #2;
        if (!reset) begin
            held_if = '0;
            held_d  = '0;
        end
        if (if_rvalid) begin
            if (if_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL if_rvalid_unexpected: got 1, expected 0 (cycle %0d)", cyc);
            end else begin
                e = if_q.pop_front();
                check("if_rdata", if_rdata, e.data);
                check("if_latency", 32'(cyc), 32'(e.cyc + 1));
                held_if = e.data;
            end
        end else begin
            check("if_rdata_hold", if_rdata, held_if);
            if (if_q.size() > 0 && if_q[0].cyc < cyc) begin
                tests++; fails++;
                $display("FAIL if_rvalid_missing: got 0, expected 1 (cycle %0d)", cyc);
                void'(if_q.pop_front());
            end
        end
        if (d_rvalid) begin
            if (d_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL d_rvalid_unexpected: got 1, expected 0 (cycle %0d)", cyc);
            end else begin
                e = d_q.pop_front();
                check("d_rdata", d_rdata, e.data);
                check("d_latency", 32'(cyc), 32'(e.cyc + 1));
                held_d = e.data;
            end
        end else begin
            check("d_rdata_hold", d_rdata, held_d);
            if (d_q.size() > 0 && d_q[0].cyc < cyc) begin
                tests++; fails++;
                $display("FAIL d_rvalid_missing: got 0, expected 1 (cycle %0d)", cyc);
                void'(d_q.pop_front());
            end
        end
    end

    function automatic logic [AW-1:0] rand_addr();
        return AW'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
    endfunction

    initial begin
        logic          gi, gd;
        logic          ir_p, dr_p, dwe_p, fl;
        logic [AW-1:0] ia_p, da_p;
        logic [31:0]   dwd_p;
        logic [3:0]    dbe_p;

        for (int i = 0; i < WORDS; i++) shadow[i] = init_word(i);
        reset = 1'b0;
        if_req = 1'b1; if_flush = 1'b0; d_req = 1'b1; d_we = 1'b0;
        if_addr = 12'h010; d_addr = 12'h100; d_wdata = '0; d_be = '0;
        repeat (2) @(negedge clk);
        apply_reset();

        // Lone fetch at 0x010 reads word 4.
        drive_cycle(1'b1, 12'h010, 1'b0, 1'b0, 1'b0, '0, '0, '0, gi, gd);
        idle_cycle();

        // Fetch and load both held: four data grants, then fetch, repeating.
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b1, 12'h040, 1'b0, 1'b1, 1'b0, 12'h100, '0, '0, gi, gd);
            check("starve_pattern", {31'd0, gi}, (i % 5 == 4) ? 32'd1 : 32'd0);
        end
        idle_cycle();

        // Partial store, then read back the merged word.
        drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 12'h020, 32'hDEAD_BEEF, 4'b0011, gi, gd);
        idle_cycle();
        drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 12'h020, '0, '0, gi, gd);
        idle_cycle();

        // Fetch followed by a flush: no response and no grant in the flush cycle.
        drive_cycle(1'b1, 12'h030, 1'b0, 1'b0, 1'b0, '0, '0, '0, gi, gd);
        drive_cycle(1'b1, 12'h034, 1'b1, 1'b0, 1'b0, '0, '0, '0, gi, gd);
        idle_cycle();

        // Load whose response is killed by reset.
        drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 12'h008, '0, '0, gi, gd);
        apply_reset();
        idle_cycle();

        // Back-to-back load then fetch.
        drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 12'h020, '0, '0, gi, gd);
        drive_cycle(1'b1, 12'h00C, 1'b0, 1'b0, 1'b0, '0, '0, '0, gi, gd);
        idle_cycle();

        // Randomized traffic with held requests, redirects and rare resets.
        ir_p = 1'b0; dr_p = 1'b0; dwe_p = 1'b0;
        ia_p = '0; da_p = '0; dwd_p = '0; dbe_p = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!ir_p && $urandom_range(0, 2) != 0) begin
                ir_p = 1'b1; ia_p = rand_addr();
            end
            if (!dr_p && $urandom_range(0, 2) != 0) begin
                dr_p  = 1'b1; da_p = rand_addr();
                dwe_p = ($urandom_range(0, 2) == 0);
                dwd_p = $urandom; dbe_p = 4'($urandom_range(0, 15));
            end
            fl = ($urandom_range(0, 7) == 0);
            if (fl && ir_p) ia_p = rand_addr();
            drive_cycle(ir_p, ia_p, fl, dr_p, dwe_p, da_p, dwd_p, dbe_p, gi, gd);
            if (gi) ir_p = 1'b0;
            if (gd) dr_p = 1'b0;
            if ($urandom_range(0, 599) == 0) begin
                apply_reset();
                ir_p = 1'b0; dr_p = 1'b0;
            end
        end
        repeat (3) idle_cycle();
        check("if_queue_drained", 32'(if_q.size()), 32'd0);
        check("d_queue_drained", 32'(d_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
